// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
// The slave modport is the arithmetic block; master is the producer/consumer side.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport slave (
        input  in_valid, A, B, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Overflow, Zero
    );

    modport master (
        output in_valid, A, B, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Overflow, Zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice iterated
// WIDTH times, LSB first, with valid/ready handshakes on both sides.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    // The single full-adder slice; sum bits enter at the MSB so the result
    // is fully aligned after WIDTH shifts.
    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_cout  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would chain shift/carry in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Subtraction is A + ~B + 1: invert B now, seed carry with 1.
                        a_sr       <= bus.A;
                        b_sr       <= bus.Sub ? ~bus.B : bus.B;
                        carry      <= bus.Sub;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry currently holds the carry into the MSB slice.
                        s_q         <= res_next;
                        cout_q      <= fa_cout;
                        ovf_q       <= carry ^ fa_cout;
                        zero_q      <= (res_next == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=4): directed corner cases,
// backpressure, mid-run reset and random operations against an arithmetic model.
module tb_serial_add_sub;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int a, input int b, input bit sub,
                                  output int s, output bit c, output bit ov, output bit z);
        int sa, sb, r;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        r  = sub ? sa - sb : sa + sb;
        s  = (sub ? a - b : a + b) & (M - 1);
        c  = sub ? (a >= b) : (a + b >= M);
        ov = (r > M / 2 - 1) || (r < -(M / 2));
        z  = (s == 0);
    endfunction

    task automatic do_op(input int a, input int b, input bit sub, input int stall);
        int n, s_exp;
        bit c_exp, ov_exp, z_exp;
        model(a, b, sub, s_exp, c_exp, ov_exp, z_exp);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(n < 50), 1);
        bus.A         = W'(a);
        bus.B         = W'(b);
        bus.Sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        // Pins must be ignored while running.
        bus.in_valid = 1'b0;
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        bus.Sub      = 1'($urandom);
        check("in_ready_run", 32'(bus.in_ready), 0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, W);
        check("S", 32'(bus.S), s_exp);
        check("Cout", 32'(bus.Cout), 32'(c_exp));
        check("Overflow", 32'(bus.Overflow), 32'(ov_exp));
        check("Zero", 32'(bus.Zero), 32'(z_exp));
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.A        = W'($urandom);
            bus.B        = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_S_held", 32'(bus.S), s_exp);
            check("bp_Cout_held", 32'(bus.Cout), 32'(c_exp));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_out_valid", 32'(bus.out_valid), 0);
        check("post_in_ready", 32'(bus.in_ready), 1);
        check("post_S_held", 32'(bus.S), s_exp);
        check("post_Ovf_held", 32'(bus.Overflow), 32'(ov_exp));
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.Sub       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_S", 32'(bus.S), 0);
        check("rst_flags", {29'd0, bus.Cout, bus.Overflow, bus.Zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3, 5, 1'b0, 0);
        do_op(5, 3, 1'b1, 0);
        do_op(3, 5, 1'b1, 0);
        do_op(7, 8, 1'b1, 0);
        do_op(15, 1, 1'b0, 0);
        do_op(0, 0, 1'b1, 0);
        do_op(8, 8, 1'b0, 0);
        // Backpressure followed directly by another op.
        do_op(9, 6, 1'b0, 3);
        do_op(2, 9, 1'b1, 0);

        // Reset during the second RUN cycle.
        bus.A        = 4'd6;
        bus.B        = 4'd7;
        bus.Sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_S", 32'(bus.S), 0);
        check("mid_rst_flags", {29'd0, bus.Cout, bus.Overflow, bus.Zero}, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        do_op(11, 4, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, M - 1), $urandom_range(0, M - 1), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
